// File: rtl/gpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gpu_mem_pkg
//  Description : Shared constants and types for the BlockRam read path.
//                Reader FSM state encoding, BlockRam read latency and the
//                reader output buffer depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } reader_state_t;

    localparam int BRAM_READ_LATENCY = 1;
    localparam int READER_FIFO_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/bram_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bram_skid_fifo
//  Description : Two-entry synchronous FIFO buffering BlockRam read data in
//                front of the output stream. Push and pop in the same cycle
//                are legal at any occupancy, including full.
//  Ports       : clock, reset      - clock, asynchronous active-high reset
//                push_i/push_data_i - write a word
//                pop_i             - remove the head word (only when count_o>0)
//                count_o           - occupancy 0..2
//                head_o            - oldest word
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_skid_fifo
    import gpu_mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] entry_q [READER_FIFO_DEPTH];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            // On full push+pop the write slot is the slot being popped; the
            // popped value is read combinationally before this edge.
            if (push_i) begin
                entry_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = entry_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/bram_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bram_burst_reader
//  Description : Reads word_count consecutive words from a single-ported
//                BlockRam (1-cycle registered read) starting at base_address
//                and delivers them in order on a valid/ready stream.
//  Ports       : clock, reset            - clock, async active-high reset
//                start, base_address,
//                word_count              - burst request (sampled in IDLE)
//                busy, done              - burst status / completion pulse
//                mem_address, mem_write,
//                mem_out_data            - BlockRam read port
//                out_valid, out_ready,
//                out_data                - output stream
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_burst_reader
    import gpu_mem_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10,
    parameter int FIFO_DEPTH    = READER_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic [ADDRESS_WIDTH:0]   word_count,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_write,
    input  logic [WORD_WIDTH-1:0]    mem_out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data
);

    localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_ONE = 1;
    localparam logic [ADDRESS_WIDTH:0]   c_CNT_ONE  = 1;
    localparam logic [2:0]               c_DEPTH    = 3'(FIFO_DEPTH);

    reader_state_t              state_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [ADDRESS_WIDTH-1:0]   mem_addr_q;
    logic [ADDRESS_WIDTH:0]     issue_left_q;
    logic [ADDRESS_WIDTH:0]     accept_left_q;
    logic                       inflight_q;

    logic [1:0]                 w_fifo_count;
    logic [2:0]                 w_occupancy;
    logic                       w_pop;
    logic                       w_issue;

    assign w_pop       = out_valid & out_ready;
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, inflight_q};

    // A slot freed by this cycle's pop may be reused by this cycle's issue,
    // which is what sustains one word per cycle with a 2-entry buffer.
    assign w_issue = (state_q == S_RUN) && (issue_left_q != '0) &&
                     ((w_occupancy < c_DEPTH) || ((w_occupancy == c_DEPTH) && w_pop));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            mem_addr_q    <= '0;
            issue_left_q  <= '0;
            accept_left_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            inflight_q <= w_issue;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q        <= base_address;
                        issue_left_q  <= word_count;
                        accept_left_q <= word_count;
                        state_q       <= (word_count == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        mem_addr_q   <= addr_q;
                        addr_q       <= addr_q + c_ADDR_ONE;
                        issue_left_q <= issue_left_q - c_CNT_ONE;
                    end
                    if (w_pop) begin
                        accept_left_q <= accept_left_q - c_CNT_ONE;
                        if (accept_left_q == c_CNT_ONE) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The issuing address is presented in its own cycle; otherwise the port
    // keeps the last address that was read.
    assign mem_address = w_issue ? addr_q : mem_addr_q;
    assign mem_write   = 1'b0;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign out_valid   = (w_fifo_count != 2'd0);

    bram_skid_fifo #(
        .WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (mem_out_data),
        .pop_i       (w_pop),
        .count_o     (w_fifo_count),
        .head_o      (out_data)
    );

endmodule
`default_nettype wire
